// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - TAP state encoding, capture constant and next-state function
// Encoding is the LFSR-style code shared with jtag_phy; IR states are DR codes with bit 3 set.
package jtag_pkg;

  typedef enum logic [3:0] {
    RUNTEST_IDLE = 4'b0000,
    SELECT_DR    = 4'b0001,
    SHIFT_DR     = 4'b0010,
    UPDATE_DR    = 4'b0011,
    CAPTURE_DR   = 4'b0100,
    EXIT1_DR     = 4'b0101,
    PAUSE_DR     = 4'b0110,
    EXIT2_DR     = 4'b0111,
    LOGIC_RESET  = 4'b1000,
    SELECT_IR    = 4'b1001,
    SHIFT_IR     = 4'b1010,
    UPDATE_IR    = 4'b1011,
    CAPTURE_IR   = 4'b1100,
    EXIT1_IR     = 4'b1101,
    PAUSE_IR     = 4'b1110,
    EXIT2_IR     = 4'b1111
  } state_t;

  localparam logic [1:0] IR_CAPTURE = 2'b01;
  localparam int IDCODE_WIDTH = 32;

  function automatic state_t tap_next(input state_t s, input logic tms);
    state_t n;
    n = LOGIC_RESET;
    case (s)
      LOGIC_RESET:            n = tms ? LOGIC_RESET : RUNTEST_IDLE;
      RUNTEST_IDLE:           n = tms ? SELECT_DR   : RUNTEST_IDLE;
      SELECT_DR:              n = tms ? SELECT_IR   : CAPTURE_DR;
      SELECT_IR:              n = tms ? LOGIC_RESET : CAPTURE_IR;
      CAPTURE_DR, SHIFT_DR:   n = tms ? EXIT1_DR    : SHIFT_DR;
      EXIT1_DR:               n = tms ? UPDATE_DR   : PAUSE_DR;
      PAUSE_DR:               n = tms ? EXIT2_DR    : PAUSE_DR;
      EXIT2_DR:               n = tms ? UPDATE_DR   : SHIFT_DR;
      CAPTURE_IR, SHIFT_IR:   n = tms ? EXIT1_IR    : SHIFT_IR;
      EXIT1_IR:               n = tms ? UPDATE_IR   : PAUSE_IR;
      PAUSE_IR:               n = tms ? EXIT2_IR    : PAUSE_IR;
      EXIT2_IR:               n = tms ? UPDATE_IR   : SHIFT_IR;
      UPDATE_DR, UPDATE_IR:   n = tms ? SELECT_DR   : RUNTEST_IDLE;
      default:                n = LOGIC_RESET;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_sync_edge.sv
// rtl/jtag_sync_edge.sv - 2-flop synchronizers for TCK/TMS/TDI with TCK edge pulses
// TMS/TDI come out with the same latency as the synchronized TCK so they line up with the edge pulse.
module jtag_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
  output logic tck_rise,
  output logic tck_fall,
  output logic tms_s,
  output logic tdi_s
);

  logic [1:0] tck_sync_q, tck_sync_d;
  logic [1:0] tms_sync_q, tms_sync_d;
  logic [1:0] tdi_sync_q, tdi_sync_d;
  logic       tck_dly_q,  tck_dly_d;

  always_comb begin
    tck_sync_d = {tck_sync_q[0], tck};
    tms_sync_d = {tms_sync_q[0], tms};
    tdi_sync_d = {tdi_sync_q[0], tdi};
    tck_dly_d  = tck_sync_q[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tck_sync_q <= '0;
      tms_sync_q <= '0;
      tdi_sync_q <= '0;
      tck_dly_q  <= 1'b0;
    end else begin
      tck_sync_q <= tck_sync_d;
      tms_sync_q <= tms_sync_d;
      tdi_sync_q <= tdi_sync_d;
      tck_dly_q  <= tck_dly_d;
    end
  end

  assign tck_rise = tck_sync_q[1] & ~tck_dly_q;
  assign tck_fall = ~tck_sync_q[1] & tck_dly_q;
  assign tms_s    = tms_sync_q[1];
  assign tdi_s    = tdi_sync_q[1];

endmodule

// File: rtl/jtag_tap_slave.sv
// rtl/jtag_tap_slave.sv - oversampled TAP responder with IDCODE, BYPASS and a fabric USER DR
// All TAP activity is qualified by TCK edge pulses derived on CLK; TDO moves only on TCK falls.
module jtag_tap_slave
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH   = 4,
  parameter int                  DR_WIDTH   = 64,
  parameter logic [31:0]         IDCODE_VAL = 32'h1BAD_C0DE,
  parameter logic [IR_WIDTH-1:0] IR_IDCODE  = 4'b0001,
  parameter logic [IR_WIDTH-1:0] IR_USER    = 4'b1000
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                TCK,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_OE,
  output logic [3:0]          TAP_STATE,
  output logic                USER_CAPTURE,
  input  logic [DR_WIDTH-1:0] USER_RDDATA,
  output logic                USER_WREN,
  output logic [DR_WIDTH-1:0] USER_WRDATA
);

  logic tck_rise, tck_fall, tms_s, tdi_s;

  jtag_sync_edge u_sync (
    .clk      (CLK),
    .rst      (RESET),
    .tck      (TCK),
    .tms      (TMS),
    .tdi      (TDI),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall),
    .tms_s    (tms_s),
    .tdi_s    (tdi_s)
  );

  state_t                  state_q,  state_d;
  logic [IR_WIDTH-1:0]     ir_q,     ir_d;
  logic [IR_WIDTH-1:0]     ir_sr_q,  ir_sr_d;
  logic [IDCODE_WIDTH-1:0] id_sr_q,  id_sr_d;
  logic [DR_WIDTH-1:0]     user_sr_q, user_sr_d;
  logic [DR_WIDTH-1:0]     wrdata_q, wrdata_d;
  logic                    byp_q,    byp_d;
  logic                    tdo_q,    tdo_d;
  logic                    tdo_oe_q, tdo_oe_d;
  logic                    cap_q,    cap_d;
  logic                    wren_q,   wren_d;
  logic                    sel_id, sel_user;

  assign sel_id   = (ir_q == IR_IDCODE);
  assign sel_user = (ir_q == IR_USER);

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    ir_sr_d   = ir_sr_q;
    id_sr_d   = id_sr_q;
    user_sr_d = user_sr_q;
    wrdata_d  = wrdata_q;
    byp_d     = byp_q;
    tdo_d     = tdo_q;
    tdo_oe_d  = tdo_oe_q;
    cap_d     = 1'b0;
    wren_d    = 1'b0;

    if (tck_rise) begin
      state_d = tap_next(state_q, tms_s);
      case (state_q)
        SHIFT_IR: ir_sr_d = {tdi_s, ir_sr_q[IR_WIDTH-1:1]};
        SHIFT_DR: begin
          if (sel_id)        id_sr_d   = {tdi_s, id_sr_q[IDCODE_WIDTH-1:1]};
          else if (sel_user) user_sr_d = {tdi_s, user_sr_q[DR_WIDTH-1:1]};
          else               byp_d     = tdi_s;
        end
        default: ;
      endcase
      // Captures and updates act on state entry; USER capture waits one CLK for USER_CAPTURE.
      case (state_d)
        CAPTURE_IR: ir_sr_d = IR_WIDTH'(IR_CAPTURE);
        UPDATE_IR:  ir_d    = ir_sr_q;
        CAPTURE_DR: begin
          if (sel_id)        id_sr_d = IDCODE_VAL;
          else if (sel_user) cap_d   = 1'b1;
          else               byp_d   = 1'b0;
        end
        UPDATE_DR: begin
          if (sel_user) begin
            wren_d   = 1'b1;
            wrdata_d = user_sr_q;
          end
        end
        default: ;
      endcase
    end

    if (cap_q) user_sr_d = USER_RDDATA;

    if (state_q == LOGIC_RESET) ir_d = IR_IDCODE;

    if (tck_fall) begin
      tdo_oe_d = (state_q == SHIFT_DR) || (state_q == SHIFT_IR);
      if (state_q == SHIFT_IR) tdo_d = ir_sr_q[0];
      else if (sel_id)         tdo_d = id_sr_q[0];
      else if (sel_user)       tdo_d = user_sr_q[0];
      else                     tdo_d = byp_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= LOGIC_RESET;
      ir_q      <= IR_IDCODE;
      ir_sr_q   <= '0;
      id_sr_q   <= '0;
      user_sr_q <= '0;
      wrdata_q  <= '0;
      byp_q     <= 1'b0;
      tdo_q     <= 1'b0;
      tdo_oe_q  <= 1'b0;
      cap_q     <= 1'b0;
      wren_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      ir_sr_q   <= ir_sr_d;
      id_sr_q   <= id_sr_d;
      user_sr_q <= user_sr_d;
      wrdata_q  <= wrdata_d;
      byp_q     <= byp_d;
      tdo_q     <= tdo_d;
      tdo_oe_q  <= tdo_oe_d;
      cap_q     <= cap_d;
      wren_q    <= wren_d;
    end
  end

  assign TDO          = tdo_q;
  assign TDO_OE       = tdo_oe_q;
  assign TAP_STATE    = state_q;
  assign USER_CAPTURE = cap_q;
  assign USER_WREN    = wren_q;
  assign USER_WRDATA  = wrdata_q;

endmodule
